// File: rtl/cdc_pkg.sv
// -----------------------------------------------------------------------------
// cdc_pkg
// Shared types and helpers for the source-side CDC transfer arbiter.
//   cdc_xfer_state_e : controller state (IDLE = may grant, WAIT = transfer
//                      outstanding, waiting for the toggled acknowledge)
//   id_width()       : width of a requester index, never less than one bit
// -----------------------------------------------------------------------------
package cdc_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } cdc_xfer_state_e;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdc_sync.sv
// -----------------------------------------------------------------------------
// cdc_sync
// Multi-flop synchronizer for signals arriving from another clock domain.
// The reset is synchronous and active-low so it can share the local reset tree.
//   clk_i   : destination-domain clock
//   rst_n_i : synchronous active-low reset, clears every stage
//   d_i     : asynchronous input
//   q_o     : d_i delayed by STAGE flops
// -----------------------------------------------------------------------------
module cdc_sync #(
    parameter int unsigned STAGE      = 2,
    parameter int unsigned DATA_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [DATA_WIDTH-1:0] sync_q [STAGE];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < STAGE; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int unsigned i = 1; i < STAGE; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGE-1];

endmodule

// File: rtl/cdc_xfer_arb.sv
// -----------------------------------------------------------------------------
// cdc_xfer_arb
// Source-side controller sharing one 2-phase bundled-data CDC channel between
// N_REQ requesters. A round-robin arbiter picks one requester, its word is
// captured into a holding register, xfer_req_o is toggled, and no further
// grant is made until the destination's toggled acknowledge (synchronized
// here) matches the request level again.
//
// Ports
//   clk_i        : source-domain clock
//   rst_i        : synchronous active-high reset
//   req_valid_i  : per-requester valid
//   req_ready_o  : per-requester ready, one-hot or zero
//   req_dat_i    : flattened payloads, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   xfer_req_o   : registered request toggle to the destination
//   xfer_ack_i   : asynchronous acknowledge toggle from the destination
//   xfer_dat_o   : registered held payload
//   xfer_id_o    : registered index of the granted requester
//   busy_o       : high while a transfer is outstanding
//   done_o       : one-cycle pulse when the acknowledge is seen
//   err_o        : sticky protocol error (acknowledge moved while idle)
// -----------------------------------------------------------------------------
module cdc_xfer_arb
    import cdc_pkg::*;
#(
    parameter  int unsigned N_REQ      = 2,
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned STAGE      = 2,
    localparam int unsigned ID_WIDTH   = id_width(N_REQ)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_REQ-1:0]            req_valid_i,
    output logic [N_REQ-1:0]            req_ready_o,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_dat_i,
    output logic                        xfer_req_o,
    input  logic                        xfer_ack_i,
    output logic [DATA_WIDTH-1:0]       xfer_dat_o,
    output logic [ID_WIDTH-1:0]         xfer_id_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o
);

    // One extra bit so ptr + offset can exceed N_REQ-1 before wrapping.
    localparam int unsigned CW = ID_WIDTH + 1;

    cdc_xfer_state_e     state_q;
    cdc_xfer_state_e     state_d;
    logic [ID_WIDTH-1:0] ptr_q;
    logic [ID_WIDTH-1:0] ptr_next;

    logic                ack_s;
    logic                ack_pend;

    logic [CW-1:0]       cand;
    logic                grant_vld;
    logic [ID_WIDTH-1:0] grant_idx;
    logic [DATA_WIDTH-1:0] grant_dat;
    logic                capture;

    // -------------------------------------------------------------------------
    // Acknowledge synchronizer
    // -------------------------------------------------------------------------
    cdc_sync #(
        .STAGE      (STAGE),
        .DATA_WIDTH (1)
    ) u_ack_sync (
        .clk_i   (clk_i),
        .rst_n_i (~rst_i),
        .d_i     (xfer_ack_i),
        .q_o     (ack_s)
    );

    assign ack_pend = (ack_s != xfer_req_o);

    // -------------------------------------------------------------------------
    // Round-robin arbiter: walk the requesters starting at ptr_q, wrapping
    // modulo N_REQ, and take the first valid one. ptr_q < N_REQ always, so a
    // single conditional subtract is enough for the wrap.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr_q} + CW'(i);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (!grant_vld && req_valid_i[cand[ID_WIDTH-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        grant_dat = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (grant_idx == ID_WIDTH'(k)) begin
                grant_dat = req_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign ptr_next = (grant_idx == ID_WIDTH'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // -------------------------------------------------------------------------
    // Controller FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        capture     = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A mismatched acknowledge while idle blocks all grants until
                // it returns to the request level.
                if (grant_vld && !ack_pend) begin
                    req_ready_o = N_REQ'(1) << grant_idx;
                    capture     = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                busy_o = 1'b1;
                if (!ack_pend) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Holding register, request toggle, pointer and error flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            xfer_req_o <= 1'b0;
            xfer_dat_o <= '0;
            xfer_id_o  <= '0;
            ptr_q      <= '0;
            err_o      <= 1'b0;
        end else begin
            if (capture) begin
                xfer_req_o <= ~xfer_req_o;
                xfer_dat_o <= grant_dat;
                xfer_id_o  <= grant_idx;
                ptr_q      <= ptr_next;
            end
            // xfer_req_o only moves on the edge that enters WAIT, so a pending
            // acknowledge observed in IDLE can only come from ack_s changing.
            if (state_q == IDLE && ack_pend) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdc_xfer_arb.sv
// -----------------------------------------------------------------------------
// tb_cdc_xfer_arb
// Self-checking bench for cdc_xfer_arb with four requesters. Inputs are driven
// 1 time unit after each rising edge and outputs sampled right after that.
// The reference model tracks the round-robin pointer as "nearest valid index
// at or after ptr, measured as a circular distance", plus the expected request
// level, held word, id and error flag.
// -----------------------------------------------------------------------------
module tb_cdc_xfer_arb;

    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned STG = 2;
    localparam int unsigned IDW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*DW-1:0]  req_dat;
    logic             xfer_req;
    logic             xfer_ack;
    logic [DW-1:0]    xfer_dat;
    logic [IDW-1:0]   xfer_id;
    logic             busy;
    logic             done;
    logic             err;

    always #5 clk = ~clk;

    cdc_xfer_arb #(
        .N_REQ      (N),
        .DATA_WIDTH (DW),
        .STAGE      (STG)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_dat_i   (req_dat),
        .xfer_req_o  (xfer_req),
        .xfer_ack_i  (xfer_ack),
        .xfer_dat_o  (xfer_dat),
        .xfer_id_o   (xfer_id),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // reference model state
    int          m_ptr;
    logic        m_req;
    logic        m_err;
    logic [DW-1:0] m_dat;
    int          m_id;
    logic [DW-1:0] words [N];

    typedef struct {
        logic [N-1:0] valid;
        int           exp_id;   // -1: no grant expected
        int unsigned  ack_dly;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_words();
        for (int k = 0; k < N; k++) req_dat[k*DW +: DW] = words[k];
    endtask

    task automatic rand_words();
        for (int k = 0; k < N; k++) words[k] = $urandom();
        pack_words();
    endtask

    function automatic int model_grant(input logic [N-1:0] v, input int p);
        int best;
        int best_d;
        int d;
        best   = -1;
        best_d = N;
        for (int k = 0; k < N; k++) begin
            if (v[k]) begin
                d = (k - p + N) % N;
                if (d < best_d) begin
                    best_d = d;
                    best   = k;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_req = 1'b0;
        m_err = 1'b0;
        m_dat = '0;
        m_id  = 0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        xfer_ack  = 1'b0;
        req_valid = '0;
        tick();
        rst = 1'b0;
        model_reset();
        check("rst xfer_req", 64'(xfer_req), 64'(0));
        check("rst xfer_dat", 64'(xfer_dat), 64'(0));
        check("rst xfer_id",  64'(xfer_id),  64'(0));
        check("rst busy",     64'(busy),     64'(0));
        check("rst done",     64'(done),     64'(0));
        check("rst err",      64'(err),      64'(0));
        check("rst ready",    64'(req_ready), 64'(0));
    endtask

    // One full transfer: offer v, expect the model's grant, let the
    // destination toggle its acknowledge ack_dly cycles after capture.
    task automatic xfer(input logic [N-1:0] v, input int unsigned ack_dly, input string tag);
        int g;
        g = model_grant(v, m_ptr);
        req_valid = v;
        #1;
        check({tag, " ready"}, 64'(req_ready), 64'(onehot(g)));
        check({tag, " idle busy"}, 64'(busy), 64'(0));
        if (g < 0) begin
            tick();
            check({tag, " no-grant req"}, 64'(xfer_req), 64'(m_req));
            check({tag, " no-grant busy"}, 64'(busy), 64'(0));
            req_valid = '0;
            return;
        end
        tick();
        m_req = ~m_req;
        m_id  = g;
        m_dat = words[g];
        m_ptr = (g + 1) % N;
        req_valid = '1;
        check({tag, " cap req"},  64'(xfer_req), 64'(m_req));
        check({tag, " cap id"},   64'(xfer_id),  64'(m_id));
        check({tag, " cap dat"},  64'(xfer_dat), 64'(m_dat));
        check({tag, " cap busy"}, 64'(busy),     64'(1));
        check({tag, " cap ready"}, 64'(req_ready), 64'(0));
        check({tag, " cap err"},  64'(err),      64'(m_err));
        for (int unsigned c = 0; c < ack_dly; c++) begin
            rand_words();
            tick();
            check({tag, " wait busy"},  64'(busy),      64'(1));
            check({tag, " wait ready"}, 64'(req_ready), 64'(0));
            check({tag, " wait dat"},   64'(xfer_dat),  64'(m_dat));
            check({tag, " wait done"},  64'(done),      64'(0));
        end
        xfer_ack = ~xfer_ack;
        for (int unsigned c = 1; c <= STG + 1; c++) begin
            tick();
            check({tag, " ack done"}, 64'(done), 64'(c == STG));
            check({tag, " ack busy"}, 64'(busy), 64'(c <= STG));
            check({tag, " ack ready"}, 64'(req_ready),
                  64'((c <= STG) ? '0 : onehot(model_grant('1, m_ptr))));
        end
        req_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        xfer_ack  = 1'b0;
        req_valid = '0;
        rand_words();
        model_reset();
        repeat (3) tick();
        do_reset();

        // single transfer from requester 0
        rand_words();
        words[0] = 32'hDEADBEEF;
        pack_words();
        xfer(4'b0001, 3, "single");
        check("single id", 64'(xfer_id), 64'(0));
        check("single dat", 64'(xfer_dat), 64'h0000_0000_DEAD_BEEF);

        // table of arbitration vectors from a fresh pointer
        do_reset();
        tbl[0]  = '{4'b1111, 0, 3};
        tbl[1]  = '{4'b1111, 1, 3};
        tbl[2]  = '{4'b1111, 2, 50};
        tbl[3]  = '{4'b1111, 3, 3};
        tbl[4]  = '{4'b1111, 0, 3};
        tbl[5]  = '{4'b1111, 1, 3};
        tbl[6]  = '{4'b1111, 2, 3};
        tbl[7]  = '{4'b0100, 2, 3};
        tbl[8]  = '{4'b1000, 3, 1};
        tbl[9]  = '{4'b0110, 1, 2};
        tbl[10] = '{4'b0011, 0, 4};
        tbl[11] = '{4'b1001, 3, 3};
        tbl[12] = '{4'b0000, -1, 0};
        tbl[13] = '{4'b0010, 1, 3};
        for (int i = 0; i < 14; i++) begin
            rand_words();
            xfer(tbl[i].valid, tbl[i].ack_dly, $sformatf("vec%0d", i));
            if (tbl[i].exp_id >= 0) begin
                check($sformatf("vec%0d id", i), 64'(xfer_id), 64'(tbl[i].exp_id));
            end
        end

        // randomized traffic
        for (int i = 0; i < 30; i++) begin
            rand_words();
            xfer(4'($urandom_range(0, 15)), $urandom_range(0, 6), $sformatf("rnd%0d", i));
        end

        // spurious acknowledge while idle
        xfer_ack = ~xfer_ack;
        for (int unsigned c = 1; c <= STG; c++) begin
            tick();
            check("spur err early", 64'(err), 64'(0));
        end
        req_valid = '1;
        #1;
        check("spur ready blocked", 64'(req_ready), 64'(0));
        for (int c = 0; c < 8; c++) begin
            tick();
            check("spur err", 64'(err), 64'(1));
            check("spur no grant", 64'(xfer_req), 64'(m_req));
            check("spur ready", 64'(req_ready), 64'(0));
            check("spur busy", 64'(busy), 64'(0));
        end
        m_err     = 1'b1;
        req_valid = '0;
        xfer_ack  = ~xfer_ack;
        repeat (STG + 1) tick();
        check("spur err sticky", 64'(err), 64'(1));
        rand_words();
        xfer(4'b1111, 2, "resume");

        // reset in the middle of a transfer
        rand_words();
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        check("midrst busy", 64'(busy), 64'(1));
        tick();
        do_reset();
        rand_words();
        xfer(4'b1111, 3, "postrst");
        check("postrst id", 64'(xfer_id), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
